// File: rtl/display_scheduler_pkg.sv
// display_scheduler_pkg
// Shared definitions for the display scan controller: decoder code
// constants and the scheduler FSM state encoding.
package display_scheduler_pkg;

    // Decoder input codes that have a meaning beyond plain digits.
    localparam logic [3:0] CODE_E     = 4'd6;
    localparam logic [3:0] CODE_N     = 4'd8;
    localparam logic [3:0] CODE_P     = 4'd9;
    localparam logic [3:0] CODE_DOT   = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    typedef enum logic [1:0] {
        CRED = 2'd0,
        PEND = 2'd1,
        MSG  = 2'd2
    } state_e;

endpackage

// File: rtl/display_scheduler_if.sv
// display_scheduler_if
// Bundle between the sales FSM (master) and the display scheduler (slave).
//   cred_valid/cred_codes : credit digit codes, digit 0 in [3:0]
//   msg_valid/msg_codes/msg_blink, msg_ready : message handshake
//   code, dig_en          : decoder code and active-low digit selects
//   msg_active, frame_tick: status outputs
interface display_scheduler_if #(
    parameter int DIGITS = 4
) ();
    logic                  cred_valid;
    logic [4*DIGITS-1:0]   cred_codes;
    logic                  msg_valid;
    logic [4*DIGITS-1:0]   msg_codes;
    logic                  msg_blink;
    logic                  msg_ready;
    logic [3:0]            code;
    logic [DIGITS-1:0]     dig_en;
    logic                  msg_active;
    logic                  frame_tick;

    modport master (
        output cred_valid, cred_codes, msg_valid, msg_codes, msg_blink,
        input  msg_ready, code, dig_en, msg_active, frame_tick
    );

    modport slave (
        input  cred_valid, cred_codes, msg_valid, msg_codes, msg_blink,
        output msg_ready, code, dig_en, msg_active, frame_tick
    );
endinterface

// File: rtl/display_scheduler_scan.sv
// scan_timer
// Slot prescaler and digit index for the multiplexed display.
//   clk, rst      : clock, async active-high reset
//   slot_tick_o   : high in the last clock of each digit slot
//   digit_idx_o   : digit currently being scanned
//   frame_tick_o  : slot tick of the last digit (frame boundary)
module scan_timer #(
    parameter int PRESCALE = 50000,
    parameter int DIGITS   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      slot_tick_o,
    output logic [$clog2(DIGITS)-1:0] digit_idx_o,
    output logic                      frame_tick_o
);
    localparam int SW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);

    logic [SW-1:0] slot_q;
    logic [IW-1:0] idx_q;
    logic          slot_tick;
    logic          last_digit;

    assign slot_tick  = (slot_q == SW'(PRESCALE - 1));
    assign last_digit = (idx_q == IW'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            idx_q  <= '0;
        end else if (slot_tick) begin
            slot_q <= '0;
            idx_q  <= last_digit ? '0 : idx_q + IW'(1);
        end else begin
            slot_q <= slot_q + SW'(1);
        end
    end

    assign slot_tick_o  = slot_tick;
    assign digit_idx_o  = idx_q;
    assign frame_tick_o = slot_tick && last_digit;
endmodule

// File: rtl/display_scheduler.sv
// display_scheduler
// Scan controller for the multi-digit 7-segment display. Shows the credit
// continuously and overlays messages for MSG_HOLD frames, optionally
// blinking. Displayed content only changes at frame boundaries.
//   clk, rst : clock, async active-high reset
//   bus      : display_scheduler_if slave (credit/message in, code/dig_en out)
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int MSG_HOLD     = 200,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                clk,
    input  logic                rst,
    display_scheduler_if.slave  bus
);
    localparam int IW = $clog2(DIGITS);
    localparam int HW = (MSG_HOLD > 1) ? $clog2(MSG_HOLD) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIGITS-1:0] DIG_EN_RST = ~DIGITS'(1);

    logic          slot_tick;
    logic          frame_tick;
    logic [IW-1:0] digit_idx;

    scan_timer #(
        .PRESCALE(PRESCALE),
        .DIGITS  (DIGITS)
    ) u_scan_timer (
        .clk         (clk),
        .rst         (rst),
        .slot_tick_o (slot_tick),
        .digit_idx_o (digit_idx),
        .frame_tick_o(frame_tick)
    );

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] cred_shadow_q, cred_shadow_d;
    logic [4*DIGITS-1:0] msg_buf_q, msg_buf_d;
    logic                blink_flag_q, blink_flag_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                phase_q, phase_d;
    logic [3:0]          code_q, code_d;
    logic [DIGITS-1:0]   dig_en_q, dig_en_d;
    logic [IW-1:0]       idx_next;

    always_comb begin
        state_d       = state_q;
        cred_shadow_d = cred_shadow_q;
        msg_buf_d     = msg_buf_q;
        blink_flag_d  = blink_flag_q;
        disp_d        = disp_q;
        hold_d        = hold_q;
        bcnt_d        = bcnt_q;
        phase_d       = phase_q;
        code_d        = code_q;
        dig_en_d      = dig_en_q;
        idx_next      = '0;

        if (bus.cred_valid) begin
            cred_shadow_d = bus.cred_codes;
        end

        case (state_q)
            CRED: begin
                if (frame_tick) begin
                    disp_d = cred_shadow_q;
                end
                if (bus.msg_valid) begin
                    msg_buf_d    = bus.msg_codes;
                    blink_flag_d = bus.msg_blink;
                    state_d      = PEND;
                end
            end
            PEND: begin
                if (frame_tick) begin
                    state_d = MSG;
                    disp_d  = msg_buf_q;
                    hold_d  = '0;
                    bcnt_d  = '0;
                    phase_d = 1'b0;
                end
            end
            MSG: begin
                if (frame_tick) begin
                    if (hold_q == HW'(MSG_HOLD - 1)) begin
                        state_d = CRED;
                        disp_d  = cred_shadow_q;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                    if (blink_flag_q) begin
                        if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                            bcnt_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end
                end
            end
            default: state_d = CRED;
        endcase

        // Output registers take the next digit's code from the next-state
        // frame, so digit 0 of a new frame already shows the new content.
        if (slot_tick) begin
            idx_next = frame_tick ? '0 : digit_idx + IW'(1);
            dig_en_d = ~(DIGITS'(1) << idx_next);
            if ((state_d == MSG) && blink_flag_q && phase_d) begin
                code_d = CODE_BLANK;
            end else begin
                code_d = disp_d[{idx_next, 2'b00} +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= CRED;
            cred_shadow_q <= '0;
            msg_buf_q     <= '0;
            blink_flag_q  <= 1'b0;
            disp_q        <= '0;
            hold_q        <= '0;
            bcnt_q        <= '0;
            phase_q       <= 1'b0;
            code_q        <= '0;
            dig_en_q      <= DIG_EN_RST;
        end else begin
            state_q       <= state_d;
            cred_shadow_q <= cred_shadow_d;
            msg_buf_q     <= msg_buf_d;
            blink_flag_q  <= blink_flag_d;
            disp_q        <= disp_d;
            hold_q        <= hold_d;
            bcnt_q        <= bcnt_d;
            phase_q       <= phase_d;
            code_q        <= code_d;
            dig_en_q      <= dig_en_d;
        end
    end

    assign bus.code       = code_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.msg_ready  = (state_q == CRED);
    assign bus.msg_active = (state_q == PEND) || (state_q == MSG);
    assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler
// Directed bench for display_scheduler with PRESCALE=4, DIGITS=4,
// MSG_HOLD=3, BLINK_FRAMES=1 (one frame = 16 clocks).
module tb_display_scheduler;
    import display_scheduler_pkg::*;

    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 4;
    localparam int MSG_HOLD     = 3;
    localparam int BLINK_FRAMES = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scheduler_if #(.DIGITS(DIGITS)) bus ();

    display_scheduler #(
        .DIGITS      (DIGITS),
        .PRESCALE    (PRESCALE),
        .MSG_HOLD    (MSG_HOLD),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        cv;
        logic [15:0] cc;
        logic        mv;
        logic [15:0] mc;
        logic        mb;
        logic        rdy;   // msg_ready one clock after the stimulus
        logic [15:0] exp;   // frame shown next, digit 0 in [3:0]
        logic        act;   // msg_active during that frame
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic cv, input logic [15:0] cc, input logic mv,
                         input logic [15:0] mc, input logic mb);
        bus.cred_valid = cv;
        bus.cred_codes = cc;
        bus.msg_valid  = mv;
        bus.msg_codes  = mc;
        bus.msg_blink  = mb;
        @(posedge clk);
        #1;
        bus.cred_valid = 1'b0;
        bus.msg_valid  = 1'b0;
        bus.msg_blink  = 1'b0;
    endtask

    task automatic wait_ftick(input string name);
        bit found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_tick === 1'b1) found = 1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s frame_tick: got none expected pulse within 64 clocks", name);
        end
    endtask

    // Samples all four digits of the frame that starts after the next
    // frame tick.
    task automatic grab_frame(input string name, input logic [15:0] exp, input logic exp_act);
        logic [15:0] e;
        logic [3:0]  en;
        e = exp;
        wait_ftick(name);
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 1 : 4) @(posedge clk);
            #1;
            en = 4'b0001 << d;
            en = ~en;
            chk($sformatf("%s dig_en d%0d", name, d), bus.dig_en, en);
            chk($sformatf("%s code d%0d", name, d), bus.code, e[d*4 +: 4]);
            if (d == 0) begin
                chk({name, " msg_active"}, bus.msg_active, exp_act);
                chk({name, " msg_ready"}, bus.msg_ready, !exp_act);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] en;
        int         cnt;
        bit         found;

        //               name         cv  cc        mv  mc        mb   rdy  exp       act
        vecs[0]  = '{"idle0",     1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[1]  = '{"cred",      1'b1, 16'h1250, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1250, 1'b0};
        vecs[2]  = '{"pen_f1",    1'b0, 16'h0000, 1'b1, 16'hF968, 1'b0, 1'b0, 16'hF968, 1'b1};
        vecs[3]  = '{"pen_f2",    1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hF968, 1'b1};
        vecs[4]  = '{"pen_f3",    1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hF968, 1'b1};
        vecs[5]  = '{"pen_back",  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1250, 1'b0};
        vecs[6]  = '{"blk_f1",    1'b0, 16'h0000, 1'b1, 16'hFFF8, 1'b1, 1'b0, 16'hFFF8, 1'b1};
        vecs[7]  = '{"blk_f2",    1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1};
        vecs[8]  = '{"blk_f3",    1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFF8, 1'b1};
        vecs[9]  = '{"blk_back",  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1250, 1'b0};
        vecs[10] = '{"col_f1",    1'b0, 16'h0000, 1'b1, 16'hF968, 1'b0, 1'b0, 16'hF968, 1'b1};
        vecs[11] = '{"col_f2",    1'b1, 16'h3333, 1'b1, 16'hAAAA, 1'b1, 1'b0, 16'hF968, 1'b1};
        vecs[12] = '{"col_f3",    1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hF968, 1'b1};
        vecs[13] = '{"col_back",  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3333, 1'b0};
        vecs[14] = '{"both_f1",   1'b1, 16'h0123, 1'b1, 16'hFFF9, 1'b0, 1'b0, 16'hFFF9, 1'b1};
        vecs[15] = '{"both_f2",   1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFF9, 1'b1};
        vecs[16] = '{"both_f3",   1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFF9, 1'b1};
        vecs[17] = '{"both_back", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0123, 1'b0};
        vecs[18] = '{"idle_cred", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0123, 1'b0};

        rst            = 1'b1;
        bus.cred_valid = 1'b0;
        bus.cred_codes = '0;
        bus.msg_valid  = 1'b0;
        bus.msg_codes  = '0;
        bus.msg_blink  = 1'b0;
        #1;
        chk("rst code", bus.code, 4'h0);
        chk("rst dig_en", bus.dig_en, 4'b1110);
        chk("rst msg_ready", bus.msg_ready, 1'b1);
        chk("rst msg_active", bus.msg_active, 1'b0);
        chk("rst frame_tick", bus.frame_tick, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].cv, vecs[i].cc, vecs[i].mv, vecs[i].mc, vecs[i].mb);
            chk({vecs[i].name, " ready_t1"}, bus.msg_ready, vecs[i].rdy);
            grab_frame(vecs[i].name, vecs[i].exp, vecs[i].act);
        end

        // frame_tick period and pulse width
        wait_ftick("period");
        cnt   = 0;
        found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (k == 0) chk("ftick width", bus.frame_tick, 1'b0);
            if (bus.frame_tick === 1'b1) found = 1;
        end
        chk("ftick period", cnt, DIGITS * PRESCALE);

        // credit update mid-frame leaves the current frame untouched
        wait_ftick("mid");
        @(posedge clk);
        #1;
        chk("mid code d0", bus.code, 4'h3);
        apply(1'b1, 16'h7777, 1'b0, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid code d1", bus.code, 4'h2);
        repeat (4) @(posedge clk);
        #1;
        chk("mid code d2", bus.code, 4'h1);
        repeat (4) @(posedge clk);
        #1;
        chk("mid code d3", bus.code, 4'h0);
        grab_frame("mid_next", 16'h7777, 1'b0);

        // asynchronous reset mid-slot, then digit walk
        found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.dig_en === 4'b1011) found = 1;
        end
        chk("arst pre dig_en", bus.dig_en, 4'b1011);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst code", bus.code, 4'h0);
        chk("arst dig_en", bus.dig_en, 4'b1110);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            en = 4'b0001 << ((k / 4) % 4);
            en = ~en;
            chk($sformatf("walk dig_en k%0d", k), bus.dig_en, en);
            chk($sformatf("walk code k%0d", k), bus.code, 4'h0);
        end

        // reset while PEND
        apply(1'b1, 16'h5555, 1'b1, 16'hF968, 1'b0);
        chk("pend msg_ready", bus.msg_ready, 1'b0);
        chk("pend msg_active", bus.msg_active, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("pend rst msg_active", bus.msg_active, 1'b0);
        chk("pend rst msg_ready", bus.msg_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        grab_frame("pend_rst_f1", 16'h0000, 1'b0);
        grab_frame("pend_rst_f2", 16'h0000, 1'b0);

        // reset while MSG
        apply(1'b1, 16'h5555, 1'b1, 16'hF968, 1'b0);
        grab_frame("msg_f1", 16'hF968, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("msg rst code", bus.code, 4'h0);
        chk("msg rst dig_en", bus.dig_en, 4'b1110);
        chk("msg rst msg_active", bus.msg_active, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        grab_frame("msg_rst_f1", 16'h0000, 1'b0);
        grab_frame("msg_rst_f2", 16'h0000, 1'b0);
        grab_frame("msg_rst_f3", 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
